// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with double-buffered digits
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   value_in     packed nibbles, nibble i = digit i (digit 0 least significant)
//   load         one-cycle strobe capturing value_in into the pending buffer
//   digit_en     per-digit enable, 0 keeps that digit dark
//   lz_blank     1 blanks leading zero digits (digit 0 is never blanked)
//   num          nibble to the shared decoder, 4'hf is the blank code
//   an           active-low anodes, at most one low at a time
//   pending      a loaded value is waiting for the next frame boundary
//   frame_tick   one-cycle pulse as a new frame begins at digit 0

module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [3:0]              num,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int MAXC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           count, count_n;
    logic [IW-1:0]           idx, idx_n;
    logic [4*NUM_DIGITS-1:0] shown;
    logic [4*NUM_DIGITS-1:0] pend_reg;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   visible;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [3:0]              num_n;
    logic                    all_zero;

    // Sequencing: one counter shared by both states, cleared on every change.
    always_comb begin
        state_n  = state;
        count_n  = count + 1'b1;
        idx_n    = idx;
        boundary = 1'b0;
        case (state)
            GUARD: begin
                if (count == GUARD_LAST) begin
                    state_n = SHOW;
                    count_n = '0;
                end
            end
            SHOW: begin
                if (count == DWELL_LAST) begin
                    state_n = GUARD;
                    count_n = '0;
                    if (idx == IDX_LAST) begin
                        idx_n    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = GUARD;
                count_n = '0;
            end
        endcase
    end

    // A digit is leading-blanked when it and every more significant digit is zero.
    always_comb begin
        visible  = '0;
        all_zero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            all_zero = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (shown[4*j +: 4] != 4'h0) begin
                    all_zero = 1'b0;
                end
            end
            visible[i] = digit_en[i] & ~(lz_blank & (i != 0) & all_zero);
        end
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_comb begin
        an_n  = '1;
        num_n = 4'hf;
        if (state_n == SHOW && visible[idx_n]) begin
            an_n[idx_n] = 1'b0;
            num_n       = shown[{idx_n, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GUARD;
            count      <= '0;
            idx        <= '0;
            shown      <= '0;
            pend_reg   <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            an         <= '1;
            num        <= 4'hf;
        end else begin
            state      <= state_n;
            count      <= count_n;
            idx        <= idx_n;
            frame_tick <= boundary;
            an         <= an_n;
            num        <= num_n;
            if (boundary) begin
                // A load landing on the boundary goes straight to the display.
                if (load) begin
                    shown    <= value_in;
                    pend_reg <= value_in;
                    pending  <= 1'b0;
                end else if (pending) begin
                    shown   <= pend_reg;
                    pending <= 1'b0;
                end
            end else if (load) begin
                pend_reg <= value_in;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed table-driven bench for seg_scan_ctrl

module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [3:0]  num;
    logic [3:0]  an;
    logic        pending;
    logic        frame_tick;

    int total;
    int bad;

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DWELL_CYCLES (4),
        .GUARD_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .num        (num),
        .an         (an),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  en;
        logic        lz;
        logic [15:0] exp_num;
        logic [3:0]  lit;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Checks frame cycles 1..19 (cycle 0 is the guard slot that carries frame_tick).
    task automatic check_scan(input logic [15:0] exp_num, input logic [3:0] lit);
        int d;
        int p;
        logic [3:0] ea;
        logic [3:0] en_;
        for (int j = 1; j < 20; j++) begin
            @(negedge clk);
            d   = j / 5;
            p   = j % 5;
            ea  = 4'b1111;
            en_ = 4'hf;
            if (p != 0 && lit[d]) begin
                ea[d] = 1'b0;
                en_   = exp_num[4*d +: 4];
            end
            check($sformatf("scan_j%0d_an_num", j), {24'd0, an, num}, {24'd0, ea, en_});
        end
    endtask

    initial begin
        int cyc;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        value_in = '0;
        load     = 1'b0;
        digit_en = 4'hf;
        lz_blank = 1'b0;

        //            value     en       lz    exp_num   lit
        vecs[0] = '{16'h0000, 4'hf,    1'b0, 16'h0000, 4'b1111};
        vecs[1] = '{16'h1234, 4'hf,    1'b0, 16'h1234, 4'b1111};
        vecs[2] = '{16'h0050, 4'hf,    1'b1, 16'hff50, 4'b0011};
        vecs[3] = '{16'h0000, 4'hf,    1'b1, 16'hfff0, 4'b0001};
        vecs[4] = '{16'h1234, 4'b0101, 1'b0, 16'hf2f4, 4'b0101};
        vecs[5] = '{16'h0f07, 4'hf,    1'b1, 16'hff07, 4'b0111};
        vecs[6] = '{16'h0500, 4'b1110, 1'b1, 16'hf50f, 4'b0110};

        @(negedge clk);
        @(negedge clk);
        check("reset_an", {28'd0, an}, 32'hf);
        check("reset_num", {28'd0, num}, 32'hf);
        check("reset_pending", {31'd0, pending}, 32'd0);
        check("reset_frame_tick", {31'd0, frame_tick}, 32'd0);

        rst_n = 1'b1;
        check_scan(16'h0000, 4'b1111);

        // frame period
        wait_tick();
        cyc = 0;
        @(negedge clk);
        cyc++;
        while (frame_tick !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("frame_period", cyc, 20);

        // cycle 0 of a frame now; run the vector table
        for (int v = 0; v < 7; v++) begin
            digit_en = vecs[v].en;
            lz_blank = vecs[v].lz;
            wait_tick();
            repeat (3) @(negedge clk);
            pulse_load(vecs[v].val);
            check($sformatf("vec%0d_pending_set", v), {31'd0, pending}, 32'd1);
            wait_tick();
            check($sformatf("vec%0d_pending_clear", v), {31'd0, pending}, 32'd0);
            check_scan(vecs[v].exp_num, vecs[v].lit);
        end

        // two loads before the boundary: last one wins
        digit_en = 4'hf;
        lz_blank = 1'b0;
        wait_tick();
        repeat (2) @(negedge clk);
        pulse_load(16'h1111);
        pulse_load(16'h2222);
        check("two_loads_pending", {31'd0, pending}, 32'd1);
        wait_tick();
        check_scan(16'h2222, 4'b1111);

        // load coincident with the boundary cycle shows in that frame
        load     = 1'b1;
        value_in = 16'h5a3c;
        @(negedge clk);
        load = 1'b0;
        check("coincident_tick", {31'd0, frame_tick}, 32'd1);
        check("coincident_pending", {31'd0, pending}, 32'd0);
        check_scan(16'h5a3c, 4'b1111);

        // asynchronous reset during digit 2 with a value pending
        @(negedge clk);
        check("pre_reset_tick", {31'd0, frame_tick}, 32'd1);
        repeat (3) @(negedge clk);
        pulse_load(16'h9876);
        check("pre_reset_pending", {31'd0, pending}, 32'd1);
        repeat (8) @(negedge clk);
        check("pre_reset_digit2", {24'd0, an, num}, {24'd0, 4'b1011, 4'ha});
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_an", {28'd0, an}, 32'hf);
        check("async_reset_num", {28'd0, num}, 32'hf);
        check("async_reset_pending", {31'd0, pending}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_scan(16'h0000, 4'b1111);
        check("post_reset_pending", {31'd0, pending}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
